seq_divider: RTL and testbench

Parametrised multi-cycle integer divider producing one quotient bit per clock using a restoring shift-subtract algorithm. It supports both signed and unsigned operation, detects divide-by-zero and signed overflow, and uses valid/ready handshakes on both the operand and result sides. It serves as the shared divide unit in the datapath, generalising the fixed 32-bit unsigned divider to any width and adding flow control.

---
 rtl/seq_divider_if.sv | 27 ++
 rtl/seq_divider.sv | 147 ++++++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master side issues operands and consumes results; the slave side is the divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, signed/unsigned,
// with divide-by-zero and signed-overflow detection and valid/ready on both sides.
module seq_divider #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] quo;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;
  logic             dz;
  logic             ovf;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dz_q;
  logic             ovf_q;

  logic             sgn;
  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dsr_abs;
  logic             dsr_zero;
  logic             ovf_det;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             accept;
  logic             res_take;

  // Operand conditioning at accept time
  assign sgn      = SIGNED_EN && bus.is_signed;
  assign dvd_neg  = sgn && bus.dividend[WIDTH-1];
  assign dsr_neg  = sgn && bus.divisor[WIDTH-1];
  assign dvd_abs  = dvd_neg ? (WIDTH'(0) - bus.dividend) : bus.dividend;
  assign dsr_abs  = dsr_neg ? (WIDTH'(0) - bus.divisor) : bus.divisor;
  assign dsr_zero = (bus.divisor == '0);
  assign ovf_det  = sgn && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.divisor);

  // Partial remainder stays below the divisor magnitude, so WIDTH+1 bits hold the trial
  assign shifted = {part, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_mag};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    res_take   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = dsr_zero ? FIXUP : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) state_next = FIXUP;
      end
      FIXUP: state_next = DONE;
      DONE: begin
        if (bus.out_ready) begin
          res_take   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd         <= '0;
      dsr_mag     <= '0;
      part        <= '0;
      quo         <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      // Divide-by-zero skips CALC, so the raw dividend is kept for the remainder
      dvd        <= dsr_zero ? bus.dividend : dvd_abs;
      dsr_mag    <= dsr_abs;
      part       <= '0;
      quo        <= '0;
      cnt        <= CNT_W'(WIDTH);
      q_neg      <= dvd_neg ^ dsr_neg;
      r_neg      <= dvd_neg;
      dz         <= dsr_zero;
      ovf        <= ovf_det;
      in_ready_q <= 1'b0;
    end else if (state == CALC) begin
      dvd  <= {dvd[WIDTH-2:0], 1'b0};
      part <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      quo  <= {quo[WIDTH-2:0], ~trial[WIDTH]};
      cnt  <= cnt - CNT_W'(1);
    end else if (state == FIXUP) begin
      out_valid_q <= 1'b1;
      dz_q        <= dz;
      ovf_q       <= ovf;
      if (dz) begin
        quotient_q  <= '1;
        remainder_q <= dvd;
      end else begin
        quotient_q  <= q_neg ? (WIDTH'(0) - quo) : quo;
        remainder_q <= r_neg ? (WIDTH'(0) - part) : part;
      end
    end else if (res_take) begin
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: 32-bit and 8-bit instances, hand-computed results,
// latency, backpressure, ignored operands and mid-operation reset.
module tb_seq_divider;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  seq_divider_if #(.WIDTH(32)) b32 ();
  seq_divider_if #(.WIDTH(8))  b8 ();

  seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  seq_divider #(.WIDTH(8),  .SIGNED_EN(1'b1)) dut8  (.clk(clk), .reset(reset), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic s, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input logic eov, input int elat);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(b32.in_ready), 64'd1);
    b32.dividend  = a;
    b32.divisor   = d;
    b32.is_signed = s;
    b32.in_valid  = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(b32.in_ready), 64'd0);
    lat = 1;
    while (!b32.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_quotient"}, 64'(b32.quotient), 64'(eq));
    chk({tag, "_remainder"}, 64'(b32.remainder), 64'(er));
    chk({tag, "_dz"}, 64'(b32.div_by_zero), 64'(edz));
    chk({tag, "_ovf"}, 64'(b32.overflow), 64'(eov));
    @(negedge clk);
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    chk({tag, "_vld_clr"}, 64'(b32.out_valid), 64'd0);
    chk({tag, "_rdy_set"}, 64'(b32.in_ready), 64'd1);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] d,
                      input logic s, input logic [7:0] eq, input logic [7:0] er,
                      input logic edz, input logic eov, input int elat);
    int lat;
    @(negedge clk);
    b8.dividend  = a;
    b8.divisor   = d;
    b8.is_signed = s;
    b8.in_valid  = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 1;
    while (!b8.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_quotient"}, 64'(b8.quotient), 64'(eq));
    chk({tag, "_remainder"}, 64'(b8.remainder), 64'(er));
    chk({tag, "_dz"}, 64'(b8.div_by_zero), 64'(edz));
    chk({tag, "_ovf"}, 64'(b8.overflow), 64'(eov));
    @(negedge clk);
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    chk({tag, "_rdy_set"}, 64'(b8.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    b32.in_valid = 1'b0; b32.dividend = '0; b32.divisor = '0; b32.is_signed = 1'b0; b32.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.dividend  = '0; b8.divisor  = '0; b8.is_signed  = 1'b0; b8.out_ready  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_quotient", 64'(b32.quotient), 64'd0);
    chk("rst_remainder", 64'(b32.remainder), 64'd0);
    chk("rst_flags", 64'({b32.div_by_zero, b32.overflow}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run32("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 1'b0, 34);
    run32("sm7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, 34);
    run32("s7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, 34);
    run32("dz_s",    32'h1234,       32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0, 2);
    run32("dz_u",    32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0, 2);
    run32("dz_neg",  32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0, 2);
    run32("ovf_s",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b1, 34);
    run32("ovf_u",   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 1'b0, 34);
    run32("max_u_1", 32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 34);

    // Backpressure with stray operands during CALC and DONE
    @(negedge clk);
    b32.dividend = 32'd100; b32.divisor = 32'd7; b32.is_signed = 1'b0; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    b32.dividend = 32'h55; b32.divisor = 32'd0; b32.in_valid = 1'b1;
    chk("bp_calc_rdy", 64'(b32.in_ready), 64'd0);
    @(negedge clk);
    b32.in_valid = 1'b0;
    lat = 0;
    while (!b32.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_quotient", 64'(b32.quotient), 64'd14);
    chk("bp_remainder", 64'(b32.remainder), 64'd2);
    chk("bp_dz", 64'(b32.div_by_zero), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b32.in_valid = i[0];
      b32.dividend = 32'h99 + 32'(i);
      b32.divisor  = 32'd3;
      chk("bp_hold_vld", 64'(b32.out_valid), 64'd1);
      chk("bp_hold_rdy", 64'(b32.in_ready), 64'd0);
      chk("bp_hold_q", 64'(b32.quotient), 64'd14);
      chk("bp_hold_r", 64'(b32.remainder), 64'd2);
    end
    b32.in_valid = 1'b0;
    @(negedge clk);
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    chk("bp_rel_vld", 64'(b32.out_valid), 64'd0);
    chk("bp_rel_rdy", 64'(b32.in_ready), 64'd1);
    chk("bp_keep_q", 64'(b32.quotient), 64'd14);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_idle_rdy", 64'(b32.in_ready), 64'd1);
    chk("bp_idle_vld", 64'(b32.out_valid), 64'd0);

    // Reset during the 10th CALC cycle
    @(negedge clk);
    b32.dividend = 32'd1000; b32.divisor = 32'd3; b32.is_signed = 1'b0; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_out_valid", 64'(b32.out_valid), 64'd0);
    chk("ar_in_ready", 64'(b32.in_ready), 64'd1);
    chk("ar_quotient", 64'(b32.quotient), 64'd0);
    chk("ar_remainder", 64'(b32.remainder), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run32("post_rst", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 34);

    // 8-bit instance
    run8("w8_sm7_2", 8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0, 10);
    run8("w8_ovf",   8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 10);
    run8("w8_u200",  8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0, 1'b0, 10);
    run8("w8_dz",    8'h85, 8'h00, 1'b1, 8'hFF, 8'h85, 1'b1, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
